// File: rtl/nec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nec_pkg
// Description : Shared types and constants for the NEC IR decoder. It holds
//               the FSM state enum, the phase windows in 10 us ticks, the
//               inter-edge timeout and the frame length. It also provides a
//               small inclusive window-compare helper.
// Revision    : 1.0  initial release
// ============================================================================
package nec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LEAD_LOW  = 3'd1,
        ST_LEAD_HIGH = 3'd2,
        ST_BIT_LOW   = 3'd3,
        ST_BIT_HIGH  = 3'd4,
        ST_STOP      = 3'd5
    } nec_state_t;

    localparam int unsigned C_CNT_W = 11;

    localparam logic [C_CNT_W-1:0] C_CNT_MAX         = 11'd2047;

    // Phase windows in 10 us ticks, both bounds inclusive.
    localparam logic [C_CNT_W-1:0] C_LEAD_LOW_MIN    = 11'd800;
    localparam logic [C_CNT_W-1:0] C_LEAD_LOW_MAX    = 11'd1000;
    localparam logic [C_CNT_W-1:0] C_LEAD_FRM_MIN    = 11'd400;
    localparam logic [C_CNT_W-1:0] C_LEAD_FRM_MAX    = 11'd500;
    localparam logic [C_CNT_W-1:0] C_LEAD_RPT_MIN    = 11'd200;
    localparam logic [C_CNT_W-1:0] C_LEAD_RPT_MAX    = 11'd250;
    localparam logic [C_CNT_W-1:0] C_BIT_LOW_MIN     = 11'd40;
    localparam logic [C_CNT_W-1:0] C_BIT_LOW_MAX     = 11'd70;
    localparam logic [C_CNT_W-1:0] C_BIT_ZERO_MIN    = 11'd40;
    localparam logic [C_CNT_W-1:0] C_BIT_ZERO_MAX    = 11'd70;
    localparam logic [C_CNT_W-1:0] C_BIT_ONE_MIN     = 11'd140;
    localparam logic [C_CNT_W-1:0] C_BIT_ONE_MAX     = 11'd190;
    localparam logic [C_CNT_W-1:0] C_STOP_LOW_MIN    = 11'd40;
    localparam logic [C_CNT_W-1:0] C_STOP_LOW_MAX    = 11'd70;

    // 11 ms without an edge aborts a frame in progress.
    localparam logic [C_CNT_W-1:0] C_TIMEOUT         = 11'd1100;

    localparam int unsigned        C_FRAME_BITS      = 32;

    function automatic logic in_win(
        input logic [C_CNT_W-1:0] val,
        input logic [C_CNT_W-1:0] lo,
        input logic [C_CNT_W-1:0] hi
    );
        return (val >= lo) && (val <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ir_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : ir_sync_edge
// Description : Two-flop synchronizer for the asynchronous IR line, reset to
//               the idle (high) level. It is followed by registered
//               falling/rising edge pulses.
// Ports       : clk_i    system clock
//               rst_i    synchronous active-high reset
//               async_i  raw asynchronous input
//               level_o  synchronized level
//               fall_o   one-cycle pulse after a synchronized high->low
//               rise_o   one-cycle pulse after a synchronized low->high
// Revision    : 1.0  initial release
// ============================================================================
module ir_sync_edge
    import nec_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic fall_o,
    output logic rise_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic fall_q,  fall_d;
    logic rise_q,  rise_d;

    always_comb begin
        sync1_d = async_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        fall_d  = prev_q & ~sync2_q;
        rise_d  = ~prev_q & sync2_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            fall_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            fall_q  <= fall_d;
            rise_q  <= rise_d;
        end
    end

    assign level_o = sync2_q;
    assign fall_o  = fall_q;
    assign rise_o  = rise_q;

endmodule
`default_nettype wire

// File: rtl/nec_ir_decoder.sv
`default_nettype none
// ============================================================================
// Module      : nec_ir_decoder
// Description : NEC infrared remote decoder. It measures each low/high phase
//               of the synchronized IR line in 10 us ticks, walks the NEC
//               frame with an FSM and publishes the address and command bytes
//               with a one-cycle irq pulse.
// Config      : NEC_REPEAT_EN - when defined, repeat codes that follow an
//               accepted frame pulse irq_o together with repeat_o.
// Ports       : clk_i      system clock (CLK_HZ, a multiple of 100 kHz)
//               rst_i      synchronous active-high reset
//               ir_i       demodulated IR line, idle high, asynchronous
//               command_o  last accepted command byte
//               address_o  last accepted address byte
//               irq_o      frame / repeat accepted pulse
//               repeat_o   repeat accepted pulse (with irq_o)
//               err_o      malformed / timed-out frame pulse
// Revision    : 1.0  initial release
// ============================================================================
module nec_ir_decoder
    import nec_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ir_i,
    output logic [7:0] command_o,
    output logic [7:0] address_o,
    output logic       irq_o,
    output logic       repeat_o,
    output logic       err_o
);

    localparam int unsigned        C_DIV        = CLK_HZ / 100_000;
    localparam int unsigned        C_PW         = (C_DIV > 1) ? $clog2(C_DIV) : 1;
    localparam logic [C_PW-1:0]    C_PRESC_LAST = C_PW'(C_DIV - 1);
    localparam logic [5:0]         C_LAST_BIT   = 6'(C_FRAME_BITS - 1);

    logic w_level;
    logic w_fall;
    logic w_rise;
    logic w_edge;
    logic w_tick;

    ir_sync_edge u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (ir_i),
        .level_o (w_level),
        .fall_o  (w_fall),
        .rise_o  (w_rise)
    );

    logic [C_PW-1:0]    presc_q,   presc_d;
    logic [C_CNT_W-1:0] cnt_q,     cnt_d;
    nec_state_t         state_q,   state_d;
    logic [5:0]         bits_q,    bits_d;
    logic [31:0]        shift_q,   shift_d;
    logic               seen_q,    seen_d;
    logic               armed_q,   armed_d;
    logic [7:0]         command_q, command_d;
    logic [7:0]         address_q, address_d;
    logic               irq_q,     irq_d;
    logic               err_q,     err_d;
`ifdef NEC_REPEAT_EN
    logic               rpt_q,     rpt_d;
    logic               repeat_q,  repeat_d;
`endif

    assign w_edge = w_fall | w_rise;
    assign w_tick = (presc_q == C_PRESC_LAST);

    always_comb begin
        presc_d   = presc_q;
        cnt_d     = cnt_q;
        state_d   = state_q;
        bits_d    = bits_q;
        shift_d   = shift_q;
        seen_d    = seen_q;
        armed_d   = armed_q;
        command_d = command_q;
        address_d = address_q;
        irq_d     = 1'b0;
        err_d     = 1'b0;
`ifdef NEC_REPEAT_EN
        rpt_d     = rpt_q;
        repeat_d  = 1'b0;
`endif

        // Phase timer: restarts on every edge so cnt_q always holds the
        // length of the phase currently in progress.
        if (w_edge) begin
            presc_d = '0;
            cnt_d   = '0;
        end else if (w_tick) begin
            presc_d = '0;
            if (cnt_q != C_CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            presc_d = presc_q + 1'b1;
        end

        // After reset the line may be in the middle of a frame. Frame starts
        // are ignored until the line has been seen idle-high for a full
        // timeout period, so the tail of an interrupted frame is swallowed
        // without raising err_o.
        if ((state_q == ST_IDLE) && w_level && (cnt_q >= C_TIMEOUT)) begin
            armed_d = 1'b1;
        end

        if ((state_q != ST_IDLE) && !w_edge && (cnt_q >= C_TIMEOUT)) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_fall && armed_q) begin
                        state_d = ST_LEAD_LOW;
                    end
                end

                ST_LEAD_LOW: begin
                    if (w_rise) begin
                        if (in_win(cnt_q, C_LEAD_LOW_MIN, C_LEAD_LOW_MAX)) begin
                            state_d = ST_LEAD_HIGH;
                        end else begin
                            state_d = ST_IDLE;
                            err_d   = 1'b1;
                        end
                    end
                end

                ST_LEAD_HIGH: begin
                    if (w_fall) begin
                        if (in_win(cnt_q, C_LEAD_FRM_MIN, C_LEAD_FRM_MAX)) begin
                            state_d = ST_BIT_LOW;
                            bits_d  = '0;
`ifdef NEC_REPEAT_EN
                            rpt_d   = 1'b0;
`endif
                        end else if (in_win(cnt_q, C_LEAD_RPT_MIN, C_LEAD_RPT_MAX)) begin
`ifdef NEC_REPEAT_EN
                            state_d = ST_STOP;
                            rpt_d   = 1'b1;
`else
                            state_d = ST_IDLE;
`endif
                        end else begin
                            state_d = ST_IDLE;
                            err_d   = 1'b1;
                        end
                    end
                end

                ST_BIT_LOW: begin
                    if (w_rise) begin
                        if (in_win(cnt_q, C_BIT_LOW_MIN, C_BIT_LOW_MAX)) begin
                            state_d = ST_BIT_HIGH;
                        end else begin
                            state_d = ST_IDLE;
                            err_d   = 1'b1;
                        end
                    end
                end

                ST_BIT_HIGH: begin
                    if (w_fall) begin
                        if (in_win(cnt_q, C_BIT_ZERO_MIN, C_BIT_ZERO_MAX) ||
                            in_win(cnt_q, C_BIT_ONE_MIN,  C_BIT_ONE_MAX)) begin
                            // LSB first: new bit enters at the top.
                            shift_d = {in_win(cnt_q, C_BIT_ONE_MIN, C_BIT_ONE_MAX),
                                       shift_q[31:1]};
                            bits_d  = bits_q + 1'b1;
                            state_d = (bits_q == C_LAST_BIT) ? ST_STOP : ST_BIT_LOW;
                        end else begin
                            state_d = ST_IDLE;
                            err_d   = 1'b1;
                        end
                    end
                end

                ST_STOP: begin
                    if (w_rise) begin
                        state_d = ST_IDLE;
                        if (!in_win(cnt_q, C_STOP_LOW_MIN, C_STOP_LOW_MAX)) begin
                            err_d = 1'b1;
`ifdef NEC_REPEAT_EN
                        end else if (rpt_q) begin
                            // A repeat with no prior frame is dropped silently.
                            if (seen_q) begin
                                irq_d    = 1'b1;
                                repeat_d = 1'b1;
                            end
`endif
                        end else if (shift_q[23:16] == ~shift_q[31:24]) begin
                            command_d = shift_q[23:16];
                            address_d = shift_q[7:0];
                            irq_d     = 1'b1;
                            seen_d    = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q   <= '0;
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
            bits_q    <= '0;
            shift_q   <= '0;
            seen_q    <= 1'b0;
            armed_q   <= 1'b0;
            command_q <= '0;
            address_q <= '0;
            irq_q     <= 1'b0;
            err_q     <= 1'b0;
`ifdef NEC_REPEAT_EN
            rpt_q     <= 1'b0;
            repeat_q  <= 1'b0;
`endif
        end else begin
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            bits_q    <= bits_d;
            shift_q   <= shift_d;
            seen_q    <= seen_d;
            armed_q   <= armed_d;
            command_q <= command_d;
            address_q <= address_d;
            irq_q     <= irq_d;
            err_q     <= err_d;
`ifdef NEC_REPEAT_EN
            rpt_q     <= rpt_d;
            repeat_q  <= repeat_d;
`endif
        end
    end

    assign command_o = command_q;
    assign address_o = address_q;
    assign irq_o     = irq_q;
    assign err_o     = err_q;
`ifdef NEC_REPEAT_EN
    assign repeat_o  = repeat_q;
`else
    assign repeat_o  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nec_ir_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_nec_ir_decoder
// Description : Directed self-checking bench for nec_ir_decoder. It runs at
//               CLK_HZ = 100 kHz so one clock equals one 10 us tick. All
//               phase lengths below are given in ticks.
// Revision    : 1.0  initial release
// ============================================================================
module tb_nec_ir_decoder;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       ir_i  = 1'b1;
    logic [7:0] command_o;
    logic [7:0] address_o;
    logic       irq_o;
    logic       repeat_o;
    logic       err_o;

    int n_chk  = 0;
    int n_fail = 0;

    int n_irq  = 0;
    int n_err  = 0;
    int n_rpt  = 0;
    int n_both = 0;
    int n_rpt_alone = 0;

    nec_ir_decoder #(.CLK_HZ(100_000)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ir_i      (ir_i),
        .command_o (command_o),
        .address_o (address_o),
        .irq_o     (irq_o),
        .repeat_o  (repeat_o),
        .err_o     (err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (irq_o)              n_irq++;
        if (err_o)              n_err++;
        if (repeat_o)           n_rpt++;
        if (irq_o && err_o)     n_both++;
        if (repeat_o && !irq_o) n_rpt_alone++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic phase(input logic lvl, input int n);
        ir_i = lvl;
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send_lead();
        phase(1'b0, 900);
        phase(1'b1, 450);
    endtask

    // Sends the first nbits of word LSB first. A one-cycle reset is
    // injected at the start of bit rst_bit (-1 for none).
    task automatic send_bits(input logic [31:0] word, input int nbits, input int rst_bit);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                ir_i  = 1'b0;
                rst_i = 1'b1;
                @(negedge clk_i);
                rst_i = 1'b0;
                phase(1'b0, 55);
            end else begin
                phase(1'b0, 56);
            end
            phase(1'b1, word[i] ? 169 : 56);
        end
    endtask

    // Full frame up to and including the stop burst; line left low.
    task automatic frame_to_stop(input logic [7:0] addr, input logic [7:0] cmd,
                                 input logic [7:0] inv, input int rst_bit);
        logic [31:0] word;
        word = {inv, cmd, ~addr, addr};
        send_lead();
        send_bits(word, 32, rst_bit);
        phase(1'b0, 56);
    endtask

    task automatic repeat_to_stop();
        phase(1'b0, 900);
        phase(1'b1, 225);
        phase(1'b0, 56);
    endtask

    int irq0, err0, rpt0;

    task automatic snap();
        irq0 = n_irq;
        err0 = n_err;
        rpt0 = n_rpt;
    endtask

    initial begin
        @(negedge clk_i);
        repeat (4) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Reset state
        chk("rst_command", {24'd0, command_o}, 32'h00);
        chk("rst_address", {24'd0, address_o}, 32'h00);
        chk("rst_irq",     {31'd0, irq_o},     32'd0);
        chk("rst_err",     {31'd0, err_o},     32'd0);
        chk("rst_repeat",  {31'd0, repeat_o},  32'd0);

        phase(1'b1, 1300);

        // 1: valid frame addr 0x00 cmd 0xA8, irq exactly at stop rise + 3
        snap();
        frame_to_stop(8'h00, 8'hA8, 8'h57, -1);
        ir_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("t1_irq_k2", {31'd0, irq_o}, 32'd0);
        @(negedge clk_i);
        chk("t1_irq_k3", {31'd0, irq_o}, 32'd1);
        chk("t1_cmd_k3", {24'd0, command_o}, 32'hA8);
        @(negedge clk_i);
        chk("t1_irq_k4", {31'd0, irq_o}, 32'd0);
        phase(1'b1, 200);
        chk("t1_command", {24'd0, command_o}, 32'hA8);
        chk("t1_address", {24'd0, address_o}, 32'h00);
        chk("t1_irq_cnt", n_irq - irq0, 1);
        chk("t1_err_cnt", n_err - err0, 0);

        // 2: cmd 0x30 with bad inverse 0xCE
        snap();
        frame_to_stop(8'h00, 8'h30, 8'hCE, -1);
        ir_i = 1'b1;
        repeat (4) @(negedge clk_i);
        chk("t2_err_k3", {31'd0, err_o}, 32'd1);
        phase(1'b1, 200);
        chk("t2_err_cnt", n_err - err0, 1);
        chk("t2_irq_cnt", n_irq - irq0, 0);
        chk("t2_command", {24'd0, command_o}, 32'hA8);

        // 3: frame cmd 0x90 then repeat code
        snap();
        frame_to_stop(8'h12, 8'h90, 8'h6F, -1);
        phase(1'b1, 300);
        chk("t3_irq_cnt", n_irq - irq0, 1);
        chk("t3_command", {24'd0, command_o}, 32'h90);
        chk("t3_address", {24'd0, address_o}, 32'h12);
        snap();
        repeat_to_stop();
        phase(1'b1, 200);
`ifdef NEC_REPEAT_EN
        chk("t3_rpt_irq", n_irq - irq0, 1);
        chk("t3_rpt_flag", n_rpt - rpt0, 1);
`else
        chk("t3_rpt_irq", n_irq - irq0, 0);
        chk("t3_rpt_flag", n_rpt - rpt0, 0);
`endif
        chk("t3_rpt_err", n_err - err0, 0);
        chk("t3_rpt_cmd", {24'd0, command_o}, 32'h90);

        // 4: repeat code right after reset (no frame seen)
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        chk("t4_cmd_rst", {24'd0, command_o}, 32'h00);
        phase(1'b1, 1300);
        snap();
        repeat_to_stop();
        phase(1'b1, 200);
        chk("t4_irq_cnt", n_irq - irq0, 0);
        chk("t4_err_cnt", n_err - err0, 0);

        // 5: line stuck low after 16 bits -> timeout, then frame 0x18
        snap();
        send_lead();
        send_bits({8'hE7, 8'h18, 8'hFF, 8'h00}, 16, -1);
        phase(1'b0, 1000);
        chk("t5_no_err_early", n_err - err0, 0);
        phase(1'b0, 200);
        chk("t5_timeout_err", n_err - err0, 1);
        chk("t5_timeout_irq", n_irq - irq0, 0);
        phase(1'b1, 300);
        snap();
        frame_to_stop(8'h00, 8'h18, 8'hE7, -1);
        phase(1'b1, 200);
        chk("t5_irq_cnt", n_irq - irq0, 1);
        chk("t5_err_cnt", n_err - err0, 0);
        chk("t5_command", {24'd0, command_o}, 32'h18);

        // 6: one-cycle reset at bit 20, then frame 0x52
        snap();
        frame_to_stop(8'h34, 8'h77, 8'h88, 20);
        phase(1'b1, 1300);
        chk("t6_irq_cnt", n_irq - irq0, 0);
        chk("t6_err_cnt", n_err - err0, 0);
        chk("t6_command", {24'd0, command_o}, 32'h00);
        snap();
        frame_to_stop(8'h5A, 8'h52, 8'hAD, -1);
        phase(1'b1, 200);
        chk("t6b_irq_cnt", n_irq - irq0, 1);
        chk("t6b_command", {24'd0, command_o}, 32'h52);
        chk("t6b_address", {24'd0, address_o}, 32'h5A);

        // 7: leader low too short (700 ticks) and bit high between windows
        snap();
        phase(1'b0, 700);
        phase(1'b1, 300);
        chk("t7_short_lead", n_err - err0, 1);
        snap();
        send_lead();
        phase(1'b0, 56);
        phase(1'b1, 100);
        phase(1'b0, 56);
        phase(1'b1, 300);
        chk("t7_bad_bit", n_err - err0, 1);
        chk("t7_cmd_kept", {24'd0, command_o}, 32'h52);

        chk("irq_err_overlap", n_both, 0);
        chk("repeat_wo_irq", n_rpt_alone, 0);

        $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
